vx_prefetch_sched: RTL
======================

# vx_prefetch_sched

Prefetch scheduler for one cache bank's request port. It detects constant-stride read-miss streams and issues prefetch requests for the next `PF_DEGREE` blocks, sharing the port with core requests at lower priority. It also tracks which prefetched blocks the core actually uses. It drives the `prefetch_requests`, `prefetched_blocks` and `unused_prefetched_blocks` fields of the cache perf-counter interface.

## Interface
- Reset is synchronous and active-low; one clock domain.
- `ADDR_WIDTH`, 26: block-address width.
- `PF_DEGREE`, 4: blocks prefetched per trigger; range 1..15.
- `PF_ENTRIES`, 8: tracking-table entries; power of 2.
- `MAX_STRIDE`, 16: largest accepted \|stride\|, in blocks.
- `PERF_CTR_BITS`, 44: counter width.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-low.
- `pf_enable` in 1: prefetching enable.
- `core_req_valid` / `core_req_ready` in / out 1: core request handshake.
- `core_req_rw` in 1: 1 = write.
- `core_req_addr` in `ADDR_WIDTH`: core block address.
- `mem_req_valid` / `mem_req_ready` out / in 1: bank-port handshake.
- `mem_req_rw` out 1: forwarded rw; 0 for prefetches.
- `mem_req_addr` out `ADDR_WIDTH`: granted address.
- `mem_req_is_pf` out 1: current grant is a prefetch.
- `miss_valid` in 1: a core read missed.
- `miss_addr` in `ADDR_WIDTH`: block address of that miss.
- `fill_valid` in 1: a block was filled.
- `fill_is_pf` in 1: the fill was caused by a prefetch.
- `fill_addr` in `ADDR_WIDTH`: filled block address.
- `evict_valid` in 1: a block was evicted.
- `evict_addr` in `ADDR_WIDTH`: evicted block address.
- `perf_prefetch_requests` out `PERF_CTR_BITS`: accepted prefetch handshakes.
- `perf_prefetched_blocks` out `PERF_CTR_BITS`: prefetch fills.
- `perf_unused_prefetched_blocks` out `PERF_CTR_BITS`: prefetched blocks dropped before any core read.

## Operation
- **Stride training (every accepted `miss_valid`)**
  - Compute `d = miss_addr - last_addr`, signed, modulo 2^`ADDR_WIDTH`.
  - If `d == last_stride`, `d != 0` and \|d\| <= `MAX_STRIDE`: this is a trigger.
  - Always update `last_addr`; update `last_stride` to `d`.
  - Out-of-range `d` clears `last_stride` to 0.
- **FSM**
  - IDLE→TRAIN: first miss after reset.
  - TRAIN→ISSUE: on a trigger with `pf_enable`=1. Load `pf_addr = miss_addr + stride` and `pf_left = PF_DEGREE`.
  - In ISSUE, each accepted prefetch adds stride to `pf_addr` and decrements `pf_left`.
  - `pf_left` reaching 0 → TRAIN.
  - A new trigger in ISSUE restarts the stream from the new miss; the trigger wins over the decrement.
  - `pf_enable`=0 → TRAIN once no prefetch is presented.
- **Arbitration**
  - Core has priority. A prefetch is presented only when `core_req_valid`=0 in ISSUE.
  - A presented prefetch is locked until `mem_req_ready`. While locked, `core_req_ready`=0.
  - Otherwise the core request passes through and `core_req_ready = mem_req_ready`.
- **Tracking table** (`PF_ENTRIES` entries: addr, valid, used)
  - Every `fill_valid && fill_is_pf` increments `perf_prefetched_blocks` and inserts an entry.
  - Insert target: the first invalid entry. If none, the round-robin victim; a victim with used=0 increments the unused counter.
  - An accepted core read whose address matches a valid entry sets used=1.
  - `evict_valid` matching a valid entry invalidates it; if used=0, the unused counter increments.
- **Same-cycle events**
  - Evict and fill in the same cycle: the evict is processed first.
  - The unused counter can increment by 2 in one cycle (evict plus victim).
- **Counters**
  - Wrap modulo 2^`PERF_CTR_BITS`.
  - Prefetch addresses wrap modulo 2^`ADDR_WIDTH`.

## Timing
- Reset values:
  - All counters 0.
  - State IDLE; table invalid; `last_stride` 0.
  - `mem_req_valid` 0, `mem_req_is_pf` 0, `core_req_ready` 0 during reset.
- The core path is combinational, with zero added latency.
- First prefetch: `mem_req_valid` rises in the cycle after the triggering miss, provided the core is idle.
- Counter and table updates are visible the cycle after the event.
- Reset asserted mid-ISSUE or mid-lock:
  - The next cycle returns to reset values.
  - A pending prefetch is dropped, not counted.

## Structure
- Shared package holds:
  - the FSM state enum (IDLE, TRAIN, ISSUE);
  - the table-entry struct;
  - the `PF_DEGREE` counter-width constant.
- Sub-module `vx_prefetch_table`: CAM lookup, insert/victim selection, used/valid bits, and the unused-count increment (0..2). The top level keeps the FSM, arbitration and counters.

## Test plan
- Misses at 0x100, 0x102, 0x104 with the core idle → prefetches to 0x106, 0x108, 0x10A, 0x10C. `perf_prefetch_requests`=4; FSM returns to TRAIN.
- Same stream, but `core_req_valid`=1 at the start of ISSUE → core granted first. Then hold `mem_req_ready`=0 for 3 cycles with the prefetch presented → `mem_req_addr` stays 0x106 and `core_req_ready`=0 throughout.
- 9 prefetch fills at 0x200..0x208, no core reads → `perf_prefetched_blocks`=9, `perf_unused_prefetched_blocks`=1.
- Fill pf 0x300, core read 0x300, evict 0x300 → unused stays 0. Fill pf 0x301, evict 0x301 → unused=1.
- Misses 0x10, 0x40, 0x70 (stride 48 > `MAX_STRIDE`) → no prefetch issued.
- Assert reset while the stream is in ISSUE with 2 blocks left → the next cycle shows IDLE, `mem_req_valid`=0 and all counters 0.

Source files
------------

// File: rtl/vx_prefetch_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vx_prefetch_sched_pkg
// Description : Shared types and constants for the prefetch scheduler:
//               FSM state encoding, tracking-table entry flags and the
//               width of the remaining-prefetch counter.
// Revision    : 1.0 - initial release
// ============================================================================
package vx_prefetch_sched_pkg;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRAIN = 2'd1,
    ST_ISSUE = 2'd2
  } pf_state_e;

  // Per-entry status of the prefetch tracking table; the block address
  // is kept in a parallel array so its width can follow ADDR_WIDTH.
  typedef struct packed {
    logic valid;
    logic used;
  } pf_entry_t;

  // Width of the blocks-left counter; covers PF_DEGREE up to 15.
  localparam int PF_LEFT_W = 4;

endpackage
`default_nettype wire

// File: rtl/vx_prefetch_table.sv
`default_nettype none
// ============================================================================
// Module      : vx_prefetch_table
// Description : Tracks prefetched blocks (addr/valid/used). CAM lookup for
//               core reads and evictions, insert into the first free slot or
//               a round-robin victim, and reports how many never-used
//               prefetched blocks were dropped this cycle (0..2).
// Revision    : 1.0 - initial release
// ============================================================================
module vx_prefetch_table
  import vx_prefetch_sched_pkg::*;
#(
  parameter int ADDR_WIDTH = 26,
  parameter int PF_ENTRIES = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fill_en,
  input  logic [ADDR_WIDTH-1:0] fill_addr,
  input  logic                  use_en,
  input  logic [ADDR_WIDTH-1:0] use_addr,
  input  logic                  evict_en,
  input  logic [ADDR_WIDTH-1:0] evict_addr,
  output logic [1:0]            unused_inc
);

  localparam int IDX_W = (PF_ENTRIES > 1) ? $clog2(PF_ENTRIES) : 1;

  pf_entry_t             ent_q  [PF_ENTRIES];
  pf_entry_t             ent_d  [PF_ENTRIES];
  logic [ADDR_WIDTH-1:0] addr_q [PF_ENTRIES];
  logic [ADDR_WIDTH-1:0] addr_d [PF_ENTRIES];
  logic [IDX_W-1:0]      rr_q, rr_d;

  logic                  evict_unused;
  logic                  victim_unused;
  logic                  free_found;
  logic [IDX_W-1:0]      ins_idx;

  // Apply core-read hits, then evictions, then the insert on the post-evict view
  always_comb begin
    evict_unused  = 1'b0;
    victim_unused = 1'b0;
    free_found    = 1'b0;
    ins_idx       = rr_q;
    rr_d          = rr_q;
    for (int i = 0; i < PF_ENTRIES; i++) begin
      ent_d[i]  = ent_q[i];
      addr_d[i] = addr_q[i];
    end
    // A core read marks the block as used before any same-cycle eviction
    for (int i = 0; i < PF_ENTRIES; i++) begin
      if (use_en && ent_q[i].valid && (addr_q[i] == use_addr)) begin
        ent_d[i].used = 1'b1;
      end
    end
    for (int i = 0; i < PF_ENTRIES; i++) begin
      if (evict_en && ent_d[i].valid && (addr_q[i] == evict_addr)) begin
        if (!ent_d[i].used) begin
          evict_unused = 1'b1;
        end
        ent_d[i].valid = 1'b0;
      end
    end
    for (int i = 0; i < PF_ENTRIES; i++) begin
      if (!free_found && !ent_d[i].valid) begin
        free_found = 1'b1;
        ins_idx    = IDX_W'(i);
      end
    end
    if (fill_en) begin
      if (!free_found) begin
        victim_unused = ent_d[rr_q].valid && !ent_d[rr_q].used;
        rr_d          = rr_q + IDX_W'(1);
      end
      ent_d[ins_idx].valid = 1'b1;
      ent_d[ins_idx].used  = 1'b0;
      addr_d[ins_idx]      = fill_addr;
    end
    unused_inc = {1'b0, evict_unused} + {1'b0, victim_unused};
  end

  // Table state registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < PF_ENTRIES; i++) begin
        ent_q[i]  <= '0;
        addr_q[i] <= '0;
      end
      rr_q <= '0;
    end else begin
      for (int i = 0; i < PF_ENTRIES; i++) begin
        ent_q[i]  <= ent_d[i];
        addr_q[i] <= addr_d[i];
      end
      rr_q <= rr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vx_prefetch_sched.sv
`default_nettype none
// ============================================================================
// Module      : vx_prefetch_sched
// Description : Constant-stride prefetch scheduler for one cache bank port.
//               Trains on read misses, issues PF_DEGREE prefetches at lower
//               priority than core requests, and maintains the prefetch
//               perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
module vx_prefetch_sched
  import vx_prefetch_sched_pkg::*;
#(
  parameter int ADDR_WIDTH    = 26,
  parameter int PF_DEGREE     = 4,
  parameter int PF_ENTRIES    = 8,
  parameter int MAX_STRIDE    = 16,
  parameter int PERF_CTR_BITS = 44
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pf_enable,
  input  logic                     core_req_valid,
  output logic                     core_req_ready,
  input  logic                     core_req_rw,
  input  logic [ADDR_WIDTH-1:0]    core_req_addr,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic                     mem_req_rw,
  output logic [ADDR_WIDTH-1:0]    mem_req_addr,
  output logic                     mem_req_is_pf,
  input  logic                     miss_valid,
  input  logic [ADDR_WIDTH-1:0]    miss_addr,
  input  logic                     fill_valid,
  input  logic                     fill_is_pf,
  input  logic [ADDR_WIDTH-1:0]    fill_addr,
  input  logic                     evict_valid,
  input  logic [ADDR_WIDTH-1:0]    evict_addr,
  output logic [PERF_CTR_BITS-1:0] perf_prefetch_requests,
  output logic [PERF_CTR_BITS-1:0] perf_prefetched_blocks,
  output logic [PERF_CTR_BITS-1:0] perf_unused_prefetched_blocks
);

  pf_state_e               state_q, state_d;
  logic [ADDR_WIDTH-1:0]   last_addr_q, last_addr_d;
  logic [ADDR_WIDTH-1:0]   last_stride_q, last_stride_d;
  logic [ADDR_WIDTH-1:0]   pf_addr_q, pf_addr_d;
  logic [ADDR_WIDTH-1:0]   pf_stride_q, pf_stride_d;
  logic [PF_LEFT_W-1:0]    pf_left_q, pf_left_d;
  logic                    lock_q, lock_d;
  logic [PERF_CTR_BITS-1:0] pf_req_q, pf_req_d;
  logic [PERF_CTR_BITS-1:0] pf_blk_q, pf_blk_d;
  logic [PERF_CTR_BITS-1:0] unused_q, unused_d;

  logic [ADDR_WIDTH-1:0]   miss_delta;
  logic [ADDR_WIDTH-1:0]   miss_delta_abs;
  logic                    stride_ok;
  logic                    trigger;
  logic                    pf_present;
  logic                    pf_accept;
  logic                    core_rd_accept;
  logic                    fill_pf;
  logic [1:0]              unused_inc;

  // Stride detection on the incoming miss (two's-complement delta)
  always_comb begin
    miss_delta     = miss_addr - last_addr_q;
    miss_delta_abs = miss_delta[ADDR_WIDTH-1] ? ((~miss_delta) + ADDR_WIDTH'(1)) : miss_delta;
    stride_ok      = (miss_delta != '0) && (miss_delta_abs <= ADDR_WIDTH'(MAX_STRIDE));
    trigger        = miss_valid && (state_q != ST_IDLE) && stride_ok &&
                     (miss_delta == last_stride_q);
  end

  // Port arbitration: core first, a presented prefetch holds the port until taken
  always_comb begin
    pf_present     = reset && (lock_q || ((state_q == ST_ISSUE) && pf_enable && !core_req_valid));
    pf_accept      = pf_present && mem_req_ready;
    mem_req_valid  = reset && (pf_present || core_req_valid);
    mem_req_rw     = pf_present ? 1'b0 : core_req_rw;
    mem_req_addr   = pf_present ? pf_addr_q : core_req_addr;
    mem_req_is_pf  = pf_present;
    core_req_ready = reset && !pf_present && mem_req_ready;
    core_rd_accept = core_req_valid && core_req_ready && !core_req_rw;
    fill_pf        = fill_valid && fill_is_pf;
  end

  // FSM next state, stream registers and perf counters
  always_comb begin
    state_d       = state_q;
    last_addr_d   = last_addr_q;
    last_stride_d = last_stride_q;
    pf_addr_d     = pf_addr_q;
    pf_stride_d   = pf_stride_q;
    pf_left_d     = pf_left_q;
    lock_d        = pf_present && !mem_req_ready;

    if (miss_valid) begin
      last_addr_d   = miss_addr;
      last_stride_d = ((state_q != ST_IDLE) && stride_ok) ? miss_delta : '0;
    end

    case (state_q)
      ST_IDLE: begin
        if (miss_valid) begin
          state_d = ST_TRAIN;
        end
      end
      ST_TRAIN: begin
        if (trigger && pf_enable) begin
          state_d     = ST_ISSUE;
          pf_addr_d   = miss_addr + miss_delta;
          pf_stride_d = miss_delta;
          pf_left_d   = PF_LEFT_W'(PF_DEGREE);
        end
      end
      ST_ISSUE: begin
        if (trigger && pf_enable) begin
          pf_addr_d   = miss_addr + miss_delta;
          pf_stride_d = miss_delta;
          pf_left_d   = PF_LEFT_W'(PF_DEGREE);
        end else if (pf_accept) begin
          pf_addr_d = pf_addr_q + pf_stride_q;
          pf_left_d = pf_left_q - PF_LEFT_W'(1);
          if (pf_left_q == PF_LEFT_W'(1)) begin
            state_d = ST_TRAIN;
          end
        end else if (!pf_enable && !lock_q) begin
          state_d = ST_TRAIN;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    pf_req_d = pf_req_q + PERF_CTR_BITS'(pf_accept);
    pf_blk_d = pf_blk_q + PERF_CTR_BITS'(fill_pf);
    unused_d = unused_q + PERF_CTR_BITS'(unused_inc);
  end

  // State and counter registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      last_addr_q   <= '0;
      last_stride_q <= '0;
      pf_addr_q     <= '0;
      pf_stride_q   <= '0;
      pf_left_q     <= '0;
      lock_q        <= 1'b0;
      pf_req_q      <= '0;
      pf_blk_q      <= '0;
      unused_q      <= '0;
    end else begin
      state_q       <= state_d;
      last_addr_q   <= last_addr_d;
      last_stride_q <= last_stride_d;
      pf_addr_q     <= pf_addr_d;
      pf_stride_q   <= pf_stride_d;
      pf_left_q     <= pf_left_d;
      lock_q        <= lock_d;
      pf_req_q      <= pf_req_d;
      pf_blk_q      <= pf_blk_d;
      unused_q      <= unused_d;
    end
  end

  assign perf_prefetch_requests        = pf_req_q;
  assign perf_prefetched_blocks        = pf_blk_q;
  assign perf_unused_prefetched_blocks = unused_q;

  vx_prefetch_table #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .PF_ENTRIES (PF_ENTRIES)
  ) u_table (
    .clk        (clk),
    .reset      (reset),
    .fill_en    (fill_pf),
    .fill_addr  (fill_addr),
    .use_en     (core_rd_accept),
    .use_addr   (core_req_addr),
    .evict_en   (evict_valid),
    .evict_addr (evict_addr),
    .unused_inc (unused_inc)
  );

endmodule
`default_nettype wire
